// File: rtl/sprite_pool_scroller_pkg.sv
// Shared definitions for the scrolling sprite pool: game-state codes, screen size,
// spawn FSM states and common coordinate/address widths.
package sprite_pool_scroller_pkg;

  typedef enum logic [1:0] {
    GAME_INIT  = 2'd0,
    GAME_START = 2'd1,
    GAME_END   = 2'd2,
    GAME_RESET = 2'd3
  } game_state_e;

  typedef enum logic {
    ST_COUNT   = 1'b0,
    ST_ATTEMPT = 1'b1
  } spawn_state_e;

  localparam int WINDOW_WIDTH  = 640;
  localparam int WINDOW_HEIGHT = 480;
  localparam int COORD_W       = 11;
  localparam int ADDR_W        = 17;
  localparam int SLOT_IDX_W    = 3;

endpackage

// File: rtl/sprite_pool_scroller_if.sv
// Control/pixel bus between game-state control, the VGA timing and the sprite pool.
interface sprite_pool_scroller_if #(
  parameter int NUM_SLOTS = 3,
  parameter int RAND_W    = 7
);
  import sprite_pool_scroller_pkg::*;

  logic                  tick;
  logic                  run;
  logic                  clear;
  logic [RAND_W-1:0]     rand_val;
  logic [9:0]            h_cnt;
  logic [9:0]            v_cnt;
  logic                  hit;
  logic [SLOT_IDX_W-1:0] hit_slot;
  logic [ADDR_W-1:0]     sprite_addr;
  logic [NUM_SLOTS-1:0]  active_mask;

  modport master (
    output tick, run, clear, rand_val, h_cnt, v_cnt,
    input  hit, hit_slot, sprite_addr, active_mask
  );

  modport slave (
    input  tick, run, clear, rand_val, h_cnt, v_cnt,
    output hit, hit_slot, sprite_addr, active_mask
  );

endinterface

// File: rtl/sprite_pool_scroller_slot.sv
// One sprite instance: enable/position registers, leftward motion with retire-on-exit,
// and the combinational coverage test plus local ROM row/column for the current pixel.
module sprite_pool_scroller_slot
  import sprite_pool_scroller_pkg::*;
#(
  parameter int SPR_W   = 52,
  parameter int SPR_H   = 19,
  parameter int SPAWN_X = 692,
  parameter int STEP    = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clear_i,
  input  logic               move_i,
  input  logic               spawn_i,
  input  logic [COORD_W-1:0] spawn_y_i,
  input  logic [COORD_W-1:0] h_i,
  input  logic [COORD_W-1:0] v_i,
  output logic               en_o,
  output logic               cov_o,
  output logic [COORD_W-1:0] row_o,
  output logic [COORD_W-1:0] col_o
);

  localparam logic [COORD_W-1:0] W_C     = 11'(SPR_W);
  localparam logic [COORD_W-1:0] H_C     = 11'(SPR_H);
  localparam logic [COORD_W-1:0] SPAWN_C = 11'(SPAWN_X);
  localparam logic [COORD_W-1:0] STEP_C  = 11'(STEP);

  logic               en_q, en_d;
  logic [COORD_W-1:0] x_q, x_d;
  logic [COORD_W-1:0] y_q, y_d;
  logic               v_in_s, h_in_s;

  // Spawn only ever targets a free slot, so it never competes with motion.
  always_comb begin
    en_d = en_q;
    x_d  = x_q;
    y_d  = y_q;
    if (clear_i) begin
      en_d = 1'b0;
      x_d  = 11'd0;
      y_d  = 11'd0;
    end else if (spawn_i) begin
      en_d = 1'b1;
      x_d  = SPAWN_C;
      y_d  = spawn_y_i;
    end else if (move_i && en_q) begin
      if (x_q <= STEP_C) begin
        en_d = 1'b0;
        x_d  = 11'd0;
        y_d  = 11'd0;
      end else begin
        x_d = x_q - STEP_C;
      end
    end else begin
      x_d = x_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      en_q <= 1'b0;
      x_q  <= 11'd0;
      y_q  <= 11'd0;
    end else begin
      en_q <= en_d;
      x_q  <= x_d;
      y_q  <= y_d;
    end
  end

  // Bounds rearranged so no subtraction can wrap below zero.
  assign v_in_s = (v_i < y_q) && ((v_i + H_C) >= y_q);
  assign h_in_s = (h_i < x_q) && ((x_q < W_C) || (h_i >= (x_q - W_C)));
  assign cov_o  = en_q && v_in_s && h_in_s;
  assign row_o  = v_i + H_C - y_q;
  assign col_o  = (x_q >= W_C) ? (h_i - (x_q - W_C)) : (h_i + (W_C - x_q));
  assign en_o   = en_q;

endmodule

// File: rtl/sprite_pool_scroller.sv
// Pool of scrolling sprite slots: gap-counter spawn FSM, lowest-free-slot selection,
// lowest-index-wins pixel hit mux and the registered ROM address/hit outputs.
module sprite_pool_scroller
  import sprite_pool_scroller_pkg::*;
#(
  parameter int NUM_SLOTS    = 3,
  parameter int SPR_W        = 52,
  parameter int SPR_H        = 19,
  parameter int SPAWN_X      = 692,
  parameter int Y_BASE       = 240,
  parameter int RAND_W       = 7,
  parameter int STEP         = 1,
  parameter int MIN_GAP      = 150,
  parameter int SKIP_THRESH  = 10,
  parameter int SKIP_BACKOFF = 80,
  parameter int FULL_BACKOFF = 50
) (
  input logic                   clk,
  input logic                   rst,
  sprite_pool_scroller_if.slave bus
);

  localparam int GAP_W = 16;
  localparam logic [GAP_W-1:0]  MIN_GAP_C   = 16'(MIN_GAP);
  localparam logic [GAP_W-1:0]  SKIP_BACK_C = 16'(SKIP_BACKOFF);
  localparam logic [GAP_W-1:0]  FULL_BACK_C = 16'(FULL_BACKOFF);
  localparam logic [RAND_W-1:0] SKIP_C      = RAND_W'(SKIP_THRESH);
  localparam logic [ADDR_W-1:0] SPR_W_A     = 17'(SPR_W);

  logic [GAP_W-1:0]      gap_q, gap_d;
  spawn_state_e          state_s;
  logic                  move_s, spawn_go_s, free_found_s;
  logic [SLOT_IDX_W-1:0] free_idx_s;
  logic [NUM_SLOTS-1:0]  en_s, cov_s, spawn_s;
  logic [COORD_W-1:0]    row_s [NUM_SLOTS];
  logic [COORD_W-1:0]    col_s [NUM_SLOTS];
  logic [COORD_W-1:0]    h_s, v_s, spawn_y_s;
  logic                  hit_q, hit_d;
  logic [SLOT_IDX_W-1:0] slot_q, slot_d;
  logic [ADDR_W-1:0]     addr_q, addr_d;

  assign move_s    = bus.tick & bus.run;
  assign h_s       = {1'b0, bus.h_cnt};
  assign v_s       = {1'b0, bus.v_cnt};
  assign spawn_y_s = 11'(Y_BASE) - 11'(bus.rand_val);
  assign state_s   = (gap_q >= MIN_GAP_C) ? ST_ATTEMPT : ST_COUNT;

  for (genvar g = 0; g < NUM_SLOTS; g++) begin : g_slot
    sprite_pool_scroller_slot #(
      .SPR_W  (SPR_W),
      .SPR_H  (SPR_H),
      .SPAWN_X(SPAWN_X),
      .STEP   (STEP)
    ) u_slot (
      .clk      (clk),
      .rst      (rst),
      .clear_i  (bus.clear),
      .move_i   (move_s),
      .spawn_i  (spawn_s[g]),
      .spawn_y_i(spawn_y_s),
      .h_i      (h_s),
      .v_i      (v_s),
      .en_o     (en_s[g]),
      .cov_o    (cov_s[g]),
      .row_o    (row_s[g]),
      .col_o    (col_s[g])
    );
  end

  // Free mask uses the pre-tick enables, so a slot retiring this tick is not reused yet.
  assign free_found_s = |(~en_s);
  always_comb begin
    free_idx_s = 3'd0;
    for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
      free_idx_s = en_s[i] ? free_idx_s : 3'(i);
    end
  end

  always_comb begin
    gap_d      = gap_q;
    spawn_go_s = 1'b0;
    if (bus.clear) begin
      gap_d = 16'd0;
    end else if (move_s) begin
      case (state_s)
        ST_COUNT: gap_d = gap_q + 16'd1;
        ST_ATTEMPT: begin
          if (!free_found_s) begin
            gap_d = FULL_BACK_C;
          end else if (bus.rand_val < SKIP_C) begin
            gap_d = SKIP_BACK_C;
          end else begin
            gap_d      = 16'd0;
            spawn_go_s = 1'b1;
          end
        end
        default: gap_d = 16'd0;
      endcase
    end else if (bus.tick) begin
      gap_d = 16'd0;
    end else begin
      gap_d = gap_q;
    end
  end

  assign spawn_s = spawn_go_s ? (NUM_SLOTS'(1) << free_idx_s) : '0;

  // Scan from the top index down so the lowest covering slot is the last writer.
  always_comb begin
    hit_d  = 1'b0;
    slot_d = 3'd0;
    addr_d = 17'd0;
    for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
      if (cov_s[i]) begin
        hit_d  = 1'b1;
        slot_d = 3'(i);
        addr_d = (17'(row_s[i]) * SPR_W_A) + 17'(col_s[i]);
      end else begin
        hit_d = hit_d;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst || bus.clear) begin
      gap_q  <= 16'd0;
      hit_q  <= 1'b0;
      slot_q <= 3'd0;
      addr_q <= 17'd0;
    end else begin
      gap_q  <= gap_d;
      hit_q  <= hit_d;
      slot_q <= slot_d;
      addr_q <= addr_d;
    end
  end

  assign bus.hit         = hit_q;
  assign bus.hit_slot    = slot_q;
  assign bus.sprite_addr = addr_q;
  assign bus.active_mask = en_s;

endmodule

// File: tb/tb_sprite_pool_scroller.sv
// Bench for sprite_pool_scroller: directed spawn/skip/backoff/retire sequences, a pixel
// lookup table, then randomized traffic checked every cycle against a behavioural model.
module tb_sprite_pool_scroller;

  localparam int N            = 3;
  localparam int SPR_W        = 52;
  localparam int SPR_H        = 19;
  localparam int SPAWN_X      = 692;
  localparam int Y_BASE       = 240;
  localparam int MIN_GAP      = 150;
  localparam int SKIP_THRESH  = 10;
  localparam int SKIP_BACKOFF = 80;
  localparam int FULL_BACKOFF = 50;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  sprite_pool_scroller_if #(.NUM_SLOTS(N), .RAND_W(7)) bus();

  sprite_pool_scroller dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int applied = 0;
  int miscompares = 0;

  // Reference model state: plain integers, one entry per slot.
  int m_en [N];
  int m_x  [N];
  int m_y  [N];
  int m_gap;
  int e_hit, e_slot, e_addr;

  typedef struct {
    int h;
    int v;
    int hit;
    int slot;
    int addr;
  } pix_vec_t;

  task automatic chk(input string name, input int act, input int exp);
    applied++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int model_mask();
    int m = 0;
    for (int i = 0; i < N; i++) if (m_en[i] != 0) m |= (1 << i);
    return m;
  endfunction

  task automatic model_zero();
    for (int i = 0; i < N; i++) begin
      m_en[i] = 0; m_x[i] = 0; m_y[i] = 0;
    end
    m_gap = 0; e_hit = 0; e_slot = 0; e_addr = 0;
  endtask

  // Applies one clock edge of the specified behaviour to the model.
  task automatic model_edge();
    int h, v, rnd, lo, k, spawn;
    h = int'(bus.h_cnt);
    v = int'(bus.v_cnt);
    rnd = int'(bus.rand_val);
    if (!rst || bus.clear) begin
      model_zero();
    end else begin
      e_hit = 0; e_slot = 0; e_addr = 0;
      for (int i = 0; i < N; i++) begin
        lo = (m_x[i] - SPR_W < 0) ? 0 : m_x[i] - SPR_W;
        if (e_hit == 0 && m_en[i] != 0 && v >= m_y[i] - SPR_H && v <= m_y[i] - 1 &&
            h >= lo && h <= m_x[i] - 1) begin
          e_hit = 1;
          e_slot = i;
          e_addr = (v - (m_y[i] - SPR_H)) * SPR_W + (h - (m_x[i] - SPR_W));
        end
      end
      if (bus.tick && bus.run) begin
        k = -1; spawn = -1;
        for (int i = N - 1; i >= 0; i--) if (m_en[i] == 0) k = i;
        if (m_gap < MIN_GAP) m_gap++;
        else if (k < 0) m_gap = FULL_BACKOFF;
        else if (rnd < SKIP_THRESH) m_gap = SKIP_BACKOFF;
        else begin m_gap = 0; spawn = k; end
        for (int i = 0; i < N; i++) begin
          if (m_en[i] != 0) begin
            if (m_x[i] <= 1) begin m_en[i] = 0; m_x[i] = 0; m_y[i] = 0; end
            else m_x[i] = m_x[i] - 1;
          end
        end
        if (spawn >= 0) begin
          m_en[spawn] = 1; m_x[spawn] = SPAWN_X; m_y[spawn] = Y_BASE - rnd;
        end
      end else if (bus.tick) begin
        m_gap = 0;
      end
    end
  endtask

  task automatic drive(input int t, input int r, input int c, input int rnd,
                       input int h, input int v);
    bus.tick = t[0]; bus.run = r[0]; bus.clear = c[0];
    bus.rand_val = rnd[6:0]; bus.h_cnt = h[9:0]; bus.v_cnt = v[9:0];
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    chk("hit", int'(bus.hit), e_hit);
    chk("hit_slot", int'(bus.hit_slot), e_slot);
    chk("sprite_addr", int'(bus.sprite_addr), e_addr);
    chk("active_mask", int'(bus.active_mask), model_mask());
  endtask

  task automatic probe(input string name, input int h, input int v,
                       input int hit, input int slot, input int addr);
    drive(0, 1, 0, 0, h, v);
    step();
    chk({name, "_hit"}, int'(bus.hit), hit);
    chk({name, "_slot"}, int'(bus.hit_slot), slot);
    chk({name, "_addr"}, int'(bus.sprite_addr), addr);
  endtask

  pix_vec_t pix_tab [8];

  initial begin
    pix_tab[0] = '{h: 260, v: 190, hit: 1, slot: 0, addr: 9 * 52 + 12};
    pix_tab[1] = '{h: 260, v: 189, hit: 1, slot: 0, addr: 8 * 52 + 12};
    pix_tab[2] = '{h: 248, v: 181, hit: 1, slot: 0, addr: 0};
    pix_tab[3] = '{h: 299, v: 199, hit: 1, slot: 0, addr: 18 * 52 + 51};
    pix_tab[4] = '{h: 247, v: 190, hit: 0, slot: 0, addr: 0};
    pix_tab[5] = '{h: 300, v: 190, hit: 0, slot: 0, addr: 0};
    pix_tab[6] = '{h: 260, v: 180, hit: 0, slot: 0, addr: 0};
    pix_tab[7] = '{h: 260, v: 200, hit: 0, slot: 0, addr: 0};

    model_zero();
    rst = 1'b0;
    drive(0, 0, 0, 0, 0, 0);
    repeat (2) step();
    chk("reset_mask", int'(bus.active_mask), 0);
    rst = 1'b1;
    for (int i = 0; i < 6; i++) probe("reset_scan", 100 * i + 40, 60 * i + 30, 0, 0, 0);

    // First spawn after MIN_GAP counting ticks, then one-pixel step.
    drive(1, 1, 0, 50, 0, 0);
    repeat (150) step();
    chk("pre_spawn_mask", int'(bus.active_mask), 0);
    step();
    chk("spawn_mask", int'(bus.active_mask), 1);
    probe("spawn_right", 691, 189, 1, 0, 18 * 52 + 51);
    probe("spawn_past_x", 692, 189, 0, 0, 0);
    probe("spawn_topleft", 640, 171, 1, 0, 0);
    probe("spawn_above", 660, 170, 0, 0, 0);
    drive(1, 1, 0, 50, 0, 0);
    step();
    probe("moved_old_edge", 691, 189, 0, 0, 0);
    probe("moved_new_edge", 690, 189, 1, 0, 18 * 52 + 51);

    // Skip on small rand, then SKIP_BACKOFF governs the next attempt.
    drive(1, 1, 0, 5, 0, 0);
    repeat (150) step();
    chk("skip_mask", int'(bus.active_mask), 1);
    drive(1, 1, 0, 50, 0, 0);
    repeat (70) step();
    chk("backoff_mask", int'(bus.active_mask), 1);
    step();
    chk("after_skip_mask", int'(bus.active_mask), 3);
    probe("slot1_pix", 691, 189, 1, 1, 18 * 52 + 51);

    drive(1, 1, 1, 50, 691, 189);
    step();
    chk("clear_hit", int'(bus.hit), 0);
    chk("clear_mask", int'(bus.active_mask), 0);

    // All slots busy: FULL_BACKOFF spaces later attempts 101 ticks apart.
    drive(1, 1, 0, 50, 0, 0);
    repeat (453) step();
    chk("full_mask", int'(bus.active_mask), 7);
    repeat (151) step();
    chk("busy_attempt_mask", int'(bus.active_mask), 7);
    repeat (302) step();
    chk("busy_retired_mask", int'(bus.active_mask), 6);
    step();
    chk("busy_respawn_mask", int'(bus.active_mask), 7);

    // Retire and attempt on the same tick: slot1 must be chosen.
    drive(0, 1, 1, 0, 0, 0);
    step();
    drive(1, 1, 0, 50, 0, 0);
    repeat (151) step();
    drive(1, 1, 0, 5, 0, 0);
    repeat (541) step();
    drive(1, 0, 0, 5, 0, 0);
    step();
    drive(1, 1, 0, 5, 0, 0);
    repeat (150) step();
    chk("pre_retire_mask", int'(bus.active_mask), 1);
    drive(1, 1, 0, 50, 0, 0);
    step();
    chk("retire_spawn_mask", int'(bus.active_mask), 2);

    // Slot0 parked at x=300, y=200 for the pixel lookup table.
    drive(0, 1, 1, 0, 0, 0);
    step();
    drive(1, 1, 0, 40, 0, 0);
    repeat (151) step();
    drive(1, 1, 0, 5, 0, 0);
    repeat (392) step();
    chk("park_mask", int'(bus.active_mask), 1);
    for (int i = 0; i < 8; i++) probe("pix_tab", pix_tab[i].h, pix_tab[i].v,
                                      pix_tab[i].hit, pix_tab[i].slot, pix_tab[i].addr);
    drive(0, 1, 1, 0, 260, 190);
    step();
    chk("pix_clear_hit", int'(bus.hit), 0);
    probe("pix_after_clear", 260, 190, 0, 0, 0);

    // Randomized traffic against the model.
    for (int n = 0; n < 4000; n++) begin
      drive(int'($urandom_range(0, 3) != 0), int'($urandom_range(0, 15) != 0),
            int'($urandom_range(0, 999) == 0), int'($urandom_range(0, 127)),
            int'($urandom_range(0, 719)), int'($urandom_range(90, 260)));
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
    $finish;
  end

endmodule
